// File: rtl/jk_bank_sequencer.sv
// Command-driven J/K drive sequencer for an external bank of WIDTH JK flip-flops.
// Optional feature macro: JK_SEQ_SHIFT_EN enables op 110 SHIFT_L (otherwise illegal).
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_HOLD, OP_CLEAR, OP_LOAD, OP_TOGGLE,
    OP_COUNT_UP, OP_COUNT_DN, OP_SHIFT_L, OP_ILLEGAL
  } op_e;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, legal_op, multi_op, last_step;
  logic [WIDTH-1:0] up_t, dn_t;

  assign accept    = cmd_valid && cmd_ready;
  assign multi_op  = cmd_op[2];
  assign last_step = (cnt == CNT_W'(1));

  always_comb begin
`ifdef JK_SEQ_SHIFT_EN
    legal_op = (cmd_op != 3'b111);
`else
    legal_op = (cmd_op[2:1] != 2'b11);
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = legal_op ? S_EXEC : S_DONE;
      S_EXEC:  if (abort || last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else if (accept) begin
      op_q    <= op_e'(cmd_op);
      data_q  <= cmd_data;
      cnt     <= (multi_op && (cmd_steps != '0)) ? cmd_steps : CNT_W'(1);
      err     <= !legal_op;
      aborted <= 1'b0;
    end else if (state == S_EXEC) begin
      cnt <= cnt - CNT_W'(1);
      if (abort) aborted <= 1'b1;
    end
  end

  // Prefix-AND carry chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & Q[i-1];
      dn_t[i] = dn_t[i-1] & ~Q[i-1];
    end
  end

`ifndef JK_SEQ_SHIFT_EN
  logic unused_q_msb;
  assign unused_q_msb = Q[WIDTH-1];
`endif

  always_comb begin
    cmd_ready = (state == S_IDLE) && !Reset;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    J         = '0;
    K         = '0;
    if (state == S_EXEC && !abort) begin
      case (op_q)
        OP_CLEAR:    K = '1;
        OP_LOAD:     begin J = data_q; K = ~data_q; end
        OP_TOGGLE:   begin J = data_q; K = data_q; end
        OP_COUNT_UP: begin J = up_t; K = up_t; end
        OP_COUNT_DN: begin J = dn_t; K = dn_t; end
`ifdef JK_SEQ_SHIFT_EN
        OP_SHIFT_L:  begin
          J = {Q[WIDTH-2:0], data_q[0]};
          K = ~{Q[WIDTH-2:0], data_q[0]};
        end
`endif
        default:     begin J = '0; K = '0; end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench for jk_bank_sequencer driving a behavioural 4-bit JK bank.
module tb_jk_bank_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_data = '0;
  logic [7:0] cmd_steps = '0;
  logic       abort = 1'b0;
  logic [3:0] Q = '0;
  logic [3:0] J, K;
  logic       busy, done, err, aborted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] q;
    logic       e;
    logic       ab;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sb[$];

  jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps), .abort(abort),
    .Q(Q), .J(J), .K(K), .busy(busy), .done(done), .err(err), .aborted(aborted)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // External JK bank model
  always @(posedge Clk) Q <= (J & ~Q) | (~K & Q);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Q", 32'(Q), 32'(e.q));
        chk("err", 32'(err), 32'(e.e));
        chk("aborted", 32'(aborted), 32'(e.ab));
        chk("done_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [7:0] steps,
                       input int abort_at, input bit track, input logic [3:0] eq,
                       input logic ee, input logic ea, input int elat);
    int   n;
    exp_t e;
    @(negedge Clk);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_steps = steps;
    @(posedge Clk);
    #1;
    if (track) begin
      e.q = eq; e.e = ee; e.ab = ea; e.lat = elat; e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge Clk);
    cmd_valid = 1'b0;
    if (abort_at > 0) begin
      for (int k = 1; k < abort_at; k++) @(negedge Clk);
      abort = 1'b1;
      @(negedge Clk);
      abort = 1'b0;
    end
    if (track) begin
      n = 0;
      while (busy && n < 100) begin
        @(negedge Clk);
        n++;
      end
      if (busy) chk("busy_timeout", 32'd1, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_J", 32'(J), 32'd0);
    chk("rst_K", 32'(K), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    Reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    issue(3'b010, 4'b1010, 8'd0,  0, 1, 4'b1010, 1'b0, 1'b0, 1);
    issue(3'b100, 4'b0000, 8'd7,  0, 1, 4'b0001, 1'b0, 1'b0, 7);
    issue(3'b001, 4'b0000, 8'd0,  0, 1, 4'b0000, 1'b0, 1'b0, 1);
    issue(3'b101, 4'b0000, 8'd0,  0, 1, 4'b1111, 1'b0, 1'b0, 1);
    issue(3'b001, 4'b0000, 8'd0,  0, 1, 4'b0000, 1'b0, 1'b0, 1);
`ifdef JK_SEQ_SHIFT_EN
    issue(3'b110, 4'b0001, 8'd3,  0, 1, 4'b0111, 1'b0, 1'b0, 3);
`else
    issue(3'b110, 4'b0001, 8'd3,  0, 1, 4'b0000, 1'b1, 1'b0, 0);
`endif
    issue(3'b010, 4'b0000, 8'd0,  0, 1, 4'b0000, 1'b0, 1'b0, 1);
    issue(3'b100, 4'b0000, 8'd10, 4, 1, 4'b0011, 1'b0, 1'b1, 4);
    issue(3'b010, 4'b0101, 8'd0,  0, 1, 4'b0101, 1'b0, 1'b0, 1);
    issue(3'b111, 4'b1111, 8'd0,  0, 1, 4'b0101, 1'b1, 1'b0, 0);
    issue(3'b011, 4'b0110, 8'd0,  0, 1, 4'b0011, 1'b0, 1'b0, 1);
    issue(3'b000, 4'b1111, 8'd5,  0, 1, 4'b0011, 1'b0, 1'b0, 1);
    issue(3'b100, 4'b0000, 8'd2,  2, 1, 4'b0100, 1'b0, 1'b1, 2);

    // Reset lands after three count edges; bank must then hold 0111.
    issue(3'b100, 4'b0000, 8'd20, 0, 0, 4'b0000, 1'b0, 1'b0, 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("midrst_J", 32'(J), 32'd0);
    chk("midrst_K", 32'(K), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_Q", 32'(Q), 32'h7);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(cmd_ready), 32'd1);
    chk("midrst_Q_held", 32'(Q), 32'h7);
    issue(3'b010, 4'b1001, 8'd0,  0, 1, 4'b1001, 1'b0, 1'b0, 1);

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
